// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO; one result bit per cycle.
// Optional `MULDIV_DIV0_FLAG_EN adds a div_zero flag pulsed with done on DIV/DIVU by zero.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
`ifdef MULDIV_DIV0_FLAG_EN
  ,
  output logic             div_zero
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_RSV0  = 3'b110,
    OP_RSV1  = 3'b111
  } op_e;

  state_e             state;
  op_e                op_r;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   a_raw, a_mag, b_mag, quo;
  logic [WIDTH:0]     rem;
  logic [2*WIDTH-1:0] acc;
  logic               neg_q, neg_r;

  op_e                op_in;
  logic               in_signed;
  logic [WIDTH:0]     sum, shifted, diff, rem_nx;
  logic [2*WIDTH-1:0] acc_nx, prod_fin;
  logic [WIDTH-1:0]   quo_nx, q_fin, r_fin;
  logic               is_mul, b_zero;

  assign op_in     = op_e'(op);
  assign in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign is_mul    = (op_r == OP_MULT) || (op_r == OP_MULTU);
  assign b_zero    = (b_mag == '0);

  // One datapath step; on the final RUN cycle the sign-corrected step result is
  // registered straight into hi/lo so it is visible during FINISH.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
    acc_nx   = {sum, acc[WIDTH-1:1]};
    shifted  = {rem[WIDTH-1:0], quo[WIDTH-1]};
    diff     = shifted - {1'b0, b_mag};
    rem_nx   = diff[WIDTH] ? shifted : diff;
    quo_nx   = {quo[WIDTH-2:0], ~diff[WIDTH]};
    prod_fin = neg_q ? -acc_nx : acc_nx;
    q_fin    = neg_q ? -quo_nx : quo_nx;
    r_fin    = neg_r ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op_r  <= OP_MULT;
      cnt   <= '0;
      a_raw <= '0;
      a_mag <= '0;
      b_mag <= '0;
      quo   <= '0;
      rem   <= '0;
      acc   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
      div_zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            case (op_in)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                op_r  <= op_in;
                a_raw <= A;
                a_mag <= (in_signed && A[WIDTH-1]) ? -A : A;
                b_mag <= (in_signed && B[WIDTH-1]) ? -B : B;
                acc   <= {{WIDTH{1'b0}}, (in_signed && B[WIDTH-1]) ? -B : B};
                quo   <= (in_signed && A[WIDTH-1]) ? -A : A;
                rem   <= '0;
                neg_q <= in_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                neg_r <= in_signed && A[WIDTH-1];
                cnt   <= '0;
                busy  <= 1'b1;
                state <= RUN;
              end
              OP_MTHI: begin
                hi   <= A;
                done <= 1'b1;
              end
              OP_MTLO: begin
                lo   <= A;
                done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          acc <= acc_nx;
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
            if (is_mul) begin
              {hi, lo} <= prod_fin;
            end else if (b_zero) begin
              hi <= a_raw;
              lo <= '1;
            end else begin
              hi <= r_fin;
              lo <= q_fin;
            end
`ifdef MULDIV_DIV0_FLAG_EN
            div_zero <= !is_mul && b_zero;
`endif
          end
        end
        default: begin
          done  <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
          div_zero <= 1'b0;
`endif
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes expected hi/lo/latency, monitor pops on done.
module tb_muldiv_unit;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] A, B;
  logic [W-1:0] hi, lo;
  logic         busy, done;
  logic         dz;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
`ifdef MULDIV_DIV0_FLAG_EN
    , .div_zero(dz)
`endif
  );

`ifndef MULDIV_DIV0_FLAG_EN
  assign dz = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          busy_cycles;
    logic        dz;
    int          start_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   busy_cnt = 0;
  int   checks = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Monitor: latency is counted in clock edges from the accept edge to the edge raising done.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
          chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
          chk({e.name, "_latency"}, 64'(cyc - e.start_cyc), 64'(e.lat));
          chk({e.name, "_busy_cycles"}, 64'(busy_cnt), 64'(e.busy_cycles));
          chk({e.name, "_busy_in_finish"}, 64'(busy), 64'd0);
`ifdef MULDIV_DIV0_FLAG_EN
          chk({e.name, "_div_zero"}, 64'(dz), 64'(e.dz));
`endif
        end
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (dz) chk("div_zero_without_done", 64'(dz), 64'd0);
      end
    end
  end

  task automatic launch(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz);
    exp_t e;
    @(negedge clk);
    op = o; A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.name = name; e.hi = ehi; e.lo = elo; e.dz = edz; e.start_cyc = cyc;
    e.lat = (o[2]) ? 0 : W;
    e.busy_cycles = (o[2]) ? 0 : W;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (exp_q.size() != 0) begin
      chk({name, "_timeout"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic run(input string name, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                     input logic edz);
    launch(name, o, a, b, ehi, elo, edz);
    drain(name);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'b000; A = '0; B = '0;
    repeat (3) @(negedge clk);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    rst = 1'b0;

    run("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run("mult_neg", 3'b000, 32'hFFFFFFF9, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0);
    run("div_neg", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run("div_negdivisor", 3'b010, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
    run("divu_zero", 3'b011, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b1);
    run("div_zero_signed", 3'b010, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
    run("mtlo", 3'b101, 32'h12345678, 32'd0, 32'hFFFFFFF9, 32'h12345678, 1'b0);
    run("mthi", 3'b100, 32'hCAFEF00D, 32'd0, 32'hCAFEF00D, 32'h12345678, 1'b0);

    // An MTHI request while DIVU is running must be dropped.
    launch("divu_busy", 3'b011, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0);
    repeat (5) @(negedge clk);
    op = 3'b100; A = 32'hDEADBEEF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("divu_busy");

    // Reset ten cycles into a MULTU aborts it without a done pulse.
    launch("multu_abort", 3'b001, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    run("multu_3x5", 3'b001, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
    run("div_overflow", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);

    // Reserved op: no busy, no done, hi/lo held.
    @(negedge clk);
    op = 3'b110; A = 32'h55555555; B = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("reserved_busy", 64'(busy), 64'd0);
    chk("reserved_done", 64'(done), 64'd0);
    repeat (40) @(negedge clk);
    chk("reserved_hi", 64'(hi), 64'd0);
    chk("reserved_lo", 64'(lo), 64'h80000000);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
